alu_seq_ctrl: RTL and testbench

Single-clock controller that shares the lab ALU datapath (ALU top with separate A/B/opcode load strobes, 32-bit shared input bus, 32-bit result F, 4-bit flags FR) between two requesters. It arbitrates round-robin, sequences clear → load A → load B → load opcode → settle → capture, then returns result and flags on a valid/ready response channel. It sits between software-facing command sources and the ALU top, replacing hand-driven per-register strobes.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/rr_arb2.sv | 29 ++
 rtl/alu_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU sequencing controller.
package alu_seq_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned FR_W     = 4;
    localparam int unsigned OP_W_DEF = 4;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StLdA,
        StLdB,
        StLdOp,
        StWait,
        StCapt,
        StResp
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-served pointer moves only on accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);

    logic r_last;

    always_comb begin
        if (i_req == 2'b11) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end else begin
            o_gnt = i_req;
        end
    end

    // Reset to "requester 1 served last" so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_accept) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Arbitrates two command sources onto the lab ALU and sequences clear/load/settle/capture,
// returning result and flags on a valid/ready response channel.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned OP_W    = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_f,
    output logic [FR_W-1:0]   rsp_fr,
    output logic              busy,
    output logic              alu_clr,
    output logic [DATA_W-1:0] alu_bus,
    output logic              alu_ld_a,
    output logic              alu_ld_b,
    output logic              alu_ld_op,
    input  logic [DATA_W-1:0] alu_f,
    input  logic [FR_W-1:0]   alu_fr
);

    localparam logic [3:0] LAT_M1 = (ALU_LAT == 0) ? 4'd0 : 4'(ALU_LAT - 1);

    state_e            r_state;
    state_e            w_state_d;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic              r_id;
    logic [3:0]        r_cnt;
    logic              r_busy;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_f;
    logic [FR_W-1:0]   r_rsp_fr;
    logic              r_alu_clr;
    logic              r_alu_ld_a;
    logic              r_alu_ld_b;
    logic              r_alu_ld_op;
    logic [DATA_W-1:0] r_alu_bus;
    logic [1:0]        w_gnt;
    logic              w_idle;
    logic              w_accept;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    ({req1_valid, req0_valid}),
        .i_accept (w_accept),
        .o_gnt    (w_gnt)
    );

    // Readies are gated by rst_n so nothing is offered while reset is held.
    assign w_idle     = (r_state == StIdle) & rst_n;
    assign req0_ready = w_idle & w_gnt[0];
    assign req1_ready = w_idle & w_gnt[1];
    assign w_accept   = req0_ready | req1_ready;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_d = StClr;
            StClr:   w_state_d = StLdA;
            StLdA:   w_state_d = StLdB;
            StLdB:   w_state_d = StLdOp;
            StLdOp:  w_state_d = (ALU_LAT == 0) ? StCapt : StWait;
            StWait:  if (r_cnt == 4'd0) w_state_d = StCapt;
            StCapt:  w_state_d = StResp;
            StResp:  if (rsp_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_id        <= 1'b0;
            r_cnt       <= 4'd0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_f     <= '0;
            r_rsp_fr    <= '0;
            r_alu_clr   <= 1'b0;
            r_alu_ld_a  <= 1'b0;
            r_alu_ld_b  <= 1'b0;
            r_alu_ld_op <= 1'b0;
            r_alu_bus   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_a  <= w_gnt[1] ? req1_a  : req0_a;
                r_b  <= w_gnt[1] ? req1_b  : req0_b;
                r_op <= w_gnt[1] ? req1_op : req0_op;
                r_id <= w_gnt[1];
            end
            if (r_state == StLdOp) begin
                r_cnt <= LAT_M1;
            end else if (r_state == StWait && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == StCapt) begin
                r_rsp_f  <= alu_f;
                r_rsp_fr <= alu_fr;
            end
            r_busy      <= (w_state_d != StIdle);
            r_rsp_valid <= (w_state_d == StResp);
            r_alu_clr   <= (w_state_d == StClr);
            r_alu_ld_a  <= (w_state_d == StLdA);
            r_alu_ld_b  <= (w_state_d == StLdB);
            r_alu_ld_op <= (w_state_d == StLdOp);
            unique case (w_state_d)
                StLdA:   r_alu_bus <= r_a;
                StLdB:   r_alu_bus <= r_b;
                StLdOp:  r_alu_bus <= DATA_W'(r_op);
                default: r_alu_bus <= '0;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_f     = r_rsp_f;
    assign rsp_fr    = r_rsp_fr;
    assign busy      = r_busy;
    assign alu_clr   = r_alu_clr;
    assign alu_bus   = r_alu_bus;
    assign alu_ld_a  = r_alu_ld_a;
    assign alu_ld_b  = r_alu_ld_b;
    assign alu_ld_op = r_alu_ld_op;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: vector table for arbitration/sequencing plus
// hand sequences for mid-sequence reset and ALU_LAT=0/3 latency.
module tb_alu_seq_ctrl;

    localparam int unsigned LAT = 1;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [3:0]  op0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [3:0]  op1;
        logic [31:0] f;
        logic [3:0]  fr;
        int          hold;
        logic        exp_id;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_f, alu_bus, alu_f;
    logic [3:0]  rsp_fr, alu_fr;
    logic        alu_clr, alu_ld_a, alu_ld_b, alu_ld_op;

    logic        x0_valid, x0_ready, x0_r1rdy, x0_rsp_valid, x0_rsp_id, x0_busy;
    logic        x0_clr, x0_lda, x0_ldb, x0_ldop;
    logic [31:0] x0_rsp_f, x0_bus, x0_alu_f;
    logic [3:0]  x0_rsp_fr;
    logic        x3_valid, x3_ready, x3_r1rdy, x3_rsp_valid, x3_rsp_id, x3_busy;
    logic        x3_clr, x3_lda, x3_ldb, x3_ldop;
    logic [31:0] x3_rsp_f, x3_bus, x3_alu_f;
    logic [3:0]  x3_rsp_fr;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[8];

    always #5 clk = ~clk;

    alu_seq_ctrl #(.ALU_LAT(LAT), .OP_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_f(rsp_f),
        .rsp_fr(rsp_fr), .busy(busy), .alu_clr(alu_clr), .alu_bus(alu_bus),
        .alu_ld_a(alu_ld_a), .alu_ld_b(alu_ld_b), .alu_ld_op(alu_ld_op),
        .alu_f(alu_f), .alu_fr(alu_fr)
    );

    alu_seq_ctrl #(.ALU_LAT(0), .OP_W(4)) u_dut_lat0 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(x0_valid), .req0_ready(x0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op),
        .req1_valid(1'b0), .req1_ready(x0_r1rdy), .req1_a(32'd0), .req1_b(32'd0),
        .req1_op(4'd0),
        .rsp_valid(x0_rsp_valid), .rsp_ready(1'b1), .rsp_id(x0_rsp_id), .rsp_f(x0_rsp_f),
        .rsp_fr(x0_rsp_fr), .busy(x0_busy), .alu_clr(x0_clr), .alu_bus(x0_bus),
        .alu_ld_a(x0_lda), .alu_ld_b(x0_ldb), .alu_ld_op(x0_ldop),
        .alu_f(x0_alu_f), .alu_fr(4'd0)
    );

    alu_seq_ctrl #(.ALU_LAT(3), .OP_W(4)) u_dut_lat3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(x3_valid), .req0_ready(x3_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op),
        .req1_valid(1'b0), .req1_ready(x3_r1rdy), .req1_a(32'd0), .req1_b(32'd0),
        .req1_op(4'd0),
        .rsp_valid(x3_rsp_valid), .rsp_ready(1'b1), .rsp_id(x3_rsp_id), .rsp_f(x3_rsp_f),
        .rsp_fr(x3_rsp_fr), .busy(x3_busy), .alu_clr(x3_clr), .alu_bus(x3_bus),
        .alu_ld_a(x3_lda), .alu_ld_b(x3_ldb), .alu_ld_op(x3_ldop),
        .alu_f(x3_alu_f), .alu_fr(4'd0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic v1, input logic [31:0] a0,
                                input logic [31:0] b0, input logic [3:0] op0,
                                input logic [31:0] a1, input logic [31:0] b1,
                                input logic [3:0] op1, input logic [31:0] f,
                                input logic [3:0] fr, input int hold, input logic exp_id);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.a0 = a0; v.b0 = b0; v.op0 = op0;
        v.a1 = a1; v.b1 = b1; v.op1 = op1; v.f = f; v.fr = fr;
        v.hold = hold; v.exp_id = exp_id;
        return v;
    endfunction

    // One transaction on the main DUT; called just after a negedge with the DUT idle.
    task automatic run_txn(input vec_t v, input string tag);
        logic [31:0] ea, eb, ebus;
        logic [3:0]  eop;
        logic [7:0]  es;
        int          t;
        ea  = v.exp_id ? v.a1  : v.a0;
        eb  = v.exp_id ? v.b1  : v.b0;
        eop = v.exp_id ? v.op1 : v.op0;
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
        rsp_ready = 1'b0;
        alu_f = ~v.f; alu_fr = ~v.fr;
        t = 0;
        #1;
        while (!(req0_ready || req1_ready) && t < 20) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 20) begin
            check({tag, " grant_timeout"}, 32'd1, 32'd0);
            return;
        end
        check({tag, " grant_wait"}, t, 0);
        check({tag, " grant"}, {req0_ready, req1_ready}, {~v.exp_id, v.exp_id});
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 5 + LAT; k++) begin
            alu_f  = (k == 4 + LAT) ? v.f  : ~v.f;
            alu_fr = (k == 4 + LAT) ? v.fr : ~v.fr;
            es = {k == 0, k == 1, k == 2, k == 3, 1'b0, 1'b1, 2'b00};
            ebus = (k == 1) ? ea : (k == 2) ? eb : (k == 3) ? {28'd0, eop} : 32'd0;
            #1;
            check($sformatf("%s seq k%0d", tag, k),
                  {alu_clr, alu_ld_a, alu_ld_b, alu_ld_op, rsp_valid, busy, req0_ready,
                   req1_ready}, es);
            check($sformatf("%s bus k%0d", tag, k), alu_bus, ebus);
            @(negedge clk);
        end
        for (int h = 0; h <= v.hold; h++) begin
            alu_f  = ~v.f ^ 32'(h + 1);
            alu_fr = ~v.fr;
            if (h < v.hold) begin
                req0_valid = 1'b1; req1_valid = 1'b1;
            end else begin
                rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
            end
            #1;
            check($sformatf("%s resp_ctl h%0d", tag, h),
                  {rsp_valid, busy, req0_ready, req1_ready, rsp_id}, {4'b1100, v.exp_id});
            check($sformatf("%s resp_f h%0d", tag, h), rsp_f, v.f);
            check($sformatf("%s resp_fr h%0d", tag, h), rsp_fr, v.fr);
            @(negedge clk);
        end
        #1;
        check({tag, " back_idle"}, {rsp_valid, busy, alu_clr, alu_ld_a, alu_ld_b, alu_ld_op},
              6'd0);
        check({tag, " idle_bus"}, alu_bus, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first0, first3;
        tbl[0] = mk(1, 1, 32'd10, 32'd20, 4'h2, 32'd30, 32'd40, 4'h3, 32'h12, 4'h1, 0, 0);
        tbl[1] = mk(1, 1, 32'd10, 32'd20, 4'h2, 32'd30, 32'd40, 4'h3, 32'h34, 4'h2, 0, 1);
        tbl[2] = mk(1, 1, 32'd11, 32'd21, 4'h2, 32'd31, 32'd41, 4'h3, 32'hDEADBEEF, 4'h8, 0, 0);
        tbl[3] = mk(1, 1, 32'd11, 32'd21, 4'h2, 32'd31, 32'd41, 4'h3, 32'h80000000, 4'h4, 0, 1);
        tbl[4] = mk(1, 0, 32'd1, 32'd2, 4'h0, 32'd0, 32'd0, 4'h0, 32'h3, 4'h0, 0, 0);
        tbl[5] = mk(0, 1, 32'd0, 32'd0, 4'h0, 32'hFFFFFFFF, 32'd0, 4'hF, 32'h12345678, 4'h5, 0, 1);
        tbl[6] = mk(0, 1, 32'd0, 32'd0, 4'h0, 32'h55AA55AA, 32'h7, 4'h9, 32'h0000FFFF, 4'h3, 0, 1);
        tbl[7] = mk(1, 0, 32'h5, 32'h6, 4'h1, 32'd0, 32'd0, 4'h0, 32'hFFFFFFFF, 4'hA, 5, 0);

        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; x0_valid = 1'b0; x3_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready = 1'b0; alu_f = '0; alu_fr = '0; x0_alu_f = '0; x3_alu_f = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctl", {req0_ready, req1_ready, rsp_valid, rsp_id, busy, alu_clr, alu_ld_a,
                            alu_ld_b, alu_ld_op}, 9'd0);
        check("reset_bus", alu_bus, 32'd0);
        check("reset_rsp", {rsp_fr, rsp_f[27:0]}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted while LD_B is on the bus must abort without a response.
        req0_valid = 1'b1; req0_a = 32'hFFFFFFFF; req0_b = 32'h1; req0_op = 4'h5;
        req1_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        check("rst_mid grant", {req0_ready, req1_ready}, 2'b10);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mid ld_b", {alu_ld_b, alu_bus[30:0]}, 32'h80000001);
        rst_n = 1'b0;
        req0_valid = 1'b1;
        #1;
        check("rst_mid ctl", {req0_ready, req1_ready, rsp_valid, rsp_id, busy, alu_clr,
                              alu_ld_a, alu_ld_b, alu_ld_op}, 9'd0);
        check("rst_mid bus", alu_bus, 32'd0);
        check("rst_mid rsp_f", rsp_f, 32'd0);
        check("rst_mid rsp_fr", {28'd0, rsp_fr}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check($sformatf("rst_hold c%0d", c), {rsp_valid, busy}, 2'b00);
        end
        req0_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(mk(1, 1, 32'h9, 32'hA, 4'h6, 32'hB, 32'hC, 4'h7, 32'h0BADCAFE, 4'h6, 0, 0),
                "post_rst");

        // Latency variants: ALU_LAT=0 and ALU_LAT=3, alu_f correct only during CAPT.
        req0_a = 32'h1; req0_b = 32'h2; req0_op = 4'h3;
        x0_valid = 1'b1; x3_valid = 1'b1;
        #1;
        check("lat grant", {x0_ready, x3_ready}, 2'b11);
        @(negedge clk);
        x0_valid = 1'b0; x3_valid = 1'b0;
        first0 = -1; first3 = -1;
        for (int k = 0; k < 13; k++) begin
            x0_alu_f = (k == 4) ? 32'hA5A50000 : 32'h0BAD0000 + 32'(k);
            x3_alu_f = (k == 7) ? 32'h5A5A1111 : 32'h0BAD3000 + 32'(k);
            #1;
            if (x0_rsp_valid && first0 < 0) first0 = k;
            if (x3_rsp_valid && first3 < 0) first3 = k;
            if (k == 5) check("lat0 rsp_f", x0_rsp_f, 32'hA5A50000);
            if (k == 8) check("lat3 rsp_f", x3_rsp_f, 32'h5A5A1111);
            @(negedge clk);
        end
        check("lat0 latency", first0, 5);
        check("lat3 latency", first3, 8);
        #1;
        check("lat0 idle", {x0_ready, x0_r1rdy, x0_rsp_valid, x0_rsp_id, x0_busy, x0_clr, x0_lda,
                            x0_ldb, x0_ldop, x0_rsp_fr}, 13'd0);
        check("lat3 idle", {x3_ready, x3_r1rdy, x3_rsp_valid, x3_rsp_id, x3_busy, x3_clr, x3_lda,
                            x3_ldb, x3_ldop, x3_rsp_fr}, 13'd0);
        check("lat idle bus", x0_bus | x3_bus, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
